// File: rtl/instr_l1_fill_ctrl.sv
// Instruction L1 miss/refill engine: requests a line burst from memory on a
// fetch miss and streams the returned words into the L1 fill port in offset order.
module instr_l1_fill_ctrl #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_SIZE      = 14,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_rd,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 l1_hit,
  output logic                 stall,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 l1_we,
  output logic [ADDR_SIZE-1:0] l1_addr,
  output logic [WORD_SIZE-1:0] l1_data,
  output logic                 fill_done
);

  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam logic [OFF-1:0]       LAST     = OFF'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t               state, state_n;
  logic [OFF-1:0]       cnt, cnt_n;
  logic [ADDR_SIZE-1:0] base, base_n;
  logic                 mem_req_n;
  logic [ADDR_SIZE-1:0] mem_addr_n;
  logic                 l1_we_n;
  logic [ADDR_SIZE-1:0] l1_addr_n;
  logic [WORD_SIZE-1:0] l1_data_n;
  logic                 fill_done_n;

  logic                 miss;
  logic [ADDR_SIZE-1:0] line_base;
  logic [ADDR_SIZE-1:0] fill_addr;

  assign miss      = cpu_rd & ~l1_hit;
  assign line_base = cpu_addr & ~OFF_MASK;
  // base has zero offset bits, so OR-ing cnt replaces them with no carry upward
  assign fill_addr = base | ADDR_SIZE'(cnt);
  assign stall     = (state != IDLE) | miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      l1_we     <= 1'b0;
      l1_addr   <= '0;
      l1_data   <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      base      <= base_n;
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
      l1_we     <= l1_we_n;
      l1_addr   <= l1_addr_n;
      l1_data   <= l1_data_n;
      fill_done <= fill_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    base_n      = base;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    l1_we_n     = 1'b0;
    l1_addr_n   = l1_addr;
    l1_data_n   = l1_data;
    fill_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss) begin
          base_n     = line_base;
          cnt_n      = '0;
          mem_req_n  = 1'b1;
          mem_addr_n = line_base;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_n = 1'b0;
          state_n   = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          l1_we_n   = 1'b1;
          l1_addr_n = fill_addr;
          l1_data_n = mem_rdata;
          cnt_n     = cnt + 1'b1;
          // last offset written: the cache validates the line on this write
          if (cnt == LAST) begin
            fill_done_n = 1'b1;
            state_n     = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
